// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared widths, op encodings, FSM states and iteration count for mul_div_unit
package mul_div_pkg;
  localparam int DATA_W = 32;
  localparam int ITER_CNT = 32;
  typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: ID/EX-side bundle; master drives start/op/src_a/src_b/cancel, slave drives busy/stall_req/hi_o/lo_o/hilo_we
interface mul_div_if;
  import mul_div_pkg::*;
  logic start;
  op_e op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic cancel;
  logic busy;
  logic stall_req;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic hilo_we;
  modport master(output start, op, src_a, src_b, cancel, input busy, stall_req, hi_o, lo_o, hilo_we);
  modport slave(input start, op, src_a, src_b, cancel, output busy, stall_req, hi_o, lo_o, hilo_we);
endinterface

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational iteration; is_div=0 shift-add (acc low half holds multiplier), is_div=1 restoring divide (acc = {rem, dividend/quotient}); opnd is multiplicand or divisor
module mul_div_step
  import mul_div_pkg::*;
(
  input  logic                is_div,
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   opnd,
  output logic [2*DATA_W-1:0] acc_nxt
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem;
  logic [DATA_W:0] diff;
  always_comb begin
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem = acc[2*DATA_W-1:DATA_W-1];
    diff = rem - {1'b0, opnd};
    acc_nxt = !is_div ? {sum, acc[DATA_W-1:1]}
            : diff[DATA_W] ? {rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
            : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU into HI/LO; ports clk, rst (sync, active-high), bus (mul_div_if.slave); define MUL_DIV_FAST_MUL_EN for single-cycle multiply
module mul_div_unit
  import mul_div_pkg::*;
(
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);
  state_e state, state_nxt;
  logic [4:0] cnt;
  logic is_div, sign_a, sign_b;
  logic [DATA_W-1:0] opnd, hi, lo, mag_a, mag_b;
  logic [2*DATA_W-1:0] acc, acc_nxt, prod, fix, ld_val;
  logic sa, sb, launch, div0, fast, last, load, busy;
  mul_div_step u_step (.is_div(is_div), .acc(acc), .opnd(opnd), .acc_nxt(acc_nxt));
`ifdef MUL_DIV_FAST_MUL_EN
  assign fast = ~bus.op[1];
  assign prod = {{DATA_W{sa}}, bus.src_a} * {{DATA_W{sb}}, bus.src_b};
`else
  assign fast = 1'b0;
  assign prod = '0;
`endif
  always_comb begin
    sa = ~bus.op[0] & bus.src_a[DATA_W-1];
    sb = ~bus.op[0] & bus.src_b[DATA_W-1];
    mag_a = sa ? -bus.src_a : bus.src_a;
    mag_b = sb ? -bus.src_b : bus.src_b;
    launch = bus.start & ~bus.cancel;
    div0 = bus.op[1] & ~|bus.src_b;
    last = cnt == 5'(ITER_CNT - 1);
    state_nxt = state == IDLE ? (launch ? (div0 | fast ? FIN : RUN) : IDLE)
              : state == RUN && !bus.cancel ? (last ? FIN : RUN) : IDLE;
    fix = is_div ? {sign_a ? -acc_nxt[2*DATA_W-1:DATA_W] : acc_nxt[2*DATA_W-1:DATA_W],
                    sign_a ^ sign_b ? -acc_nxt[DATA_W-1:0] : acc_nxt[DATA_W-1:0]}
                 : sign_a ^ sign_b ? -acc_nxt : acc_nxt;
    load = state == IDLE ? launch & (div0 | fast) : state == RUN & ~bus.cancel & last;
    ld_val = state == IDLE ? (div0 ? {bus.src_a, {DATA_W{1'b1}}} : prod) : fix;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd <= '0;
      acc <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (state == IDLE && launch) begin
        cnt <= '0;
        is_div <= bus.op[1];
        sign_a <= sa;
        sign_b <= sb;
        opnd <= bus.op[1] ? mag_b : mag_a;
        acc <= {{DATA_W{1'b0}}, bus.op[1] ? mag_a : mag_b};
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 5'd1;
      end
      if (load) {hi, lo} <= ld_val;
    end
  end
  assign busy = state != IDLE;
  assign bus.busy = busy;
  assign bus.stall_req = bus.start | busy;
  assign bus.hilo_we = state == FIN & ~bus.cancel;
  assign bus.hi_o = hi;
  assign bus.lo_o = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit covering results, write timing, cancel, reset and back-to-back launches
module tb_mul_div_unit;
  import mul_div_pkg::*;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n = 0;
  int tests = 0;
  int fails = 0;
  logic sr_n;
  logic [63:0] exp_q[$];
  mul_div_if bus();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input op_e o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic int lat_of(input op_e o, input logic [31:0] b);
    return o[1] ? ((b == 0) ? 1 : 33) : MUL_LAT;
  endfunction

  task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.src_a = a;
    bus.src_b = b;
    exp_q.push_back(model(o, a, b));
    n = cyc;
    #1 sr_n = bus.stall_req;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_we(output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bcnt += int'(bus.busy);
      if (bus.hilo_we) begin
        lat = cyc - n;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if ({bus.busy, bus.hilo_we, bus.stall_req} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b exp 000", {bus.busy, bus.hilo_we, bus.stall_req}); end
    tests++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin fails++; $display("FAIL reset_hilo: got %h exp 0", {bus.hi_o, bus.lo_o}); end
    rst = 1'b0;
  endtask

  task automatic test_mult;
    int lat, bcnt;
    logic [63:0] e;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    tests++; if (sr_n !== 1'b1) begin fails++; $display("FAIL mult_stall_n: got %b exp 1", sr_n); end
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== MUL_LAT) begin fails++; $display("FAIL mult_lat: got %0d exp %0d", lat, MUL_LAT); end
    tests++; if (bcnt !== MUL_LAT) begin fails++; $display("FAIL mult_busy_cycles: got %0d exp %0d", bcnt, MUL_LAT); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL mult_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
    @(negedge clk);
    tests++; if ({bus.hilo_we, bus.busy, bus.stall_req} !== 3'b000) begin fails++; $display("FAIL mult_after: got %b exp 000", {bus.hilo_we, bus.busy, bus.stall_req}); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== MUL_LAT) begin fails++; $display("FAIL multu_lat: got %0d exp %0d", lat, MUL_LAT); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL multu_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
  endtask

  task automatic test_divide;
    op_e ops[4] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
    logic [31:0] as[4] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] bs[4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int lat, bcnt;
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_we(lat, bcnt);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      tests++; if (lat !== 33) begin fails++; $display("FAIL div%0d_lat: got %0d exp 33", i, lat); end
      tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL div%0d_val: got %h exp %h", i, {bus.hi_o, bus.lo_o}, e); end
    end
  endtask

  task automatic test_div0;
    int lat, bcnt;
    logic [63:0] e;
    issue(OP_DIV, 32'd5, 32'd0);
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== 1) begin fails++; $display("FAIL div0_lat: got %0d exp 1", lat); end
    tests++; if (bcnt !== 1) begin fails++; $display("FAIL div0_busy_cycles: got %0d exp 1", bcnt); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL div0_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL div0_after_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_cancel;
    logic [63:0] old;
    logic seen;
    old = {bus.hi_o, bus.lo_o};
    issue(OP_DIVU, 32'd100, 32'd7);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    tests++; if ({bus.busy, bus.stall_req} !== 2'b00) begin fails++; $display("FAIL cancel_idle: got %b exp 00", {bus.busy, bus.stall_req}); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.hilo_we;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL cancel_no_we: got %b exp 0", seen); end
    tests++; if ({bus.hi_o, bus.lo_o} !== old) begin fails++; $display("FAIL cancel_stale: got %h exp %h", {bus.hi_o, bus.lo_o}, old); end
    issue(OP_DIVU, 32'd9, 32'd4);
    void'(exp_q.pop_back());
    repeat (32) @(negedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    #1;
    tests++; if (bus.hilo_we !== 1'b0) begin fails++; $display("FAIL cancel_fin_we: got %b exp 0", bus.hilo_we); end
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL cancel_fin_busy: got %b exp 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.op = OP_MULT;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.cancel = 1'b0; end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_cancel_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    logic [63:0] e;
    issue(OP_MULT, 32'd1234, 32'd5678);
    void'(exp_q.pop_back());
    repeat (19) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({bus.busy, bus.hilo_we, bus.stall_req} !== 3'b000) begin fails++; $display("FAIL rstmid_ctrl: got %b exp 000", {bus.busy, bus.hilo_we, bus.stall_req}); end
    tests++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin fails++; $display("FAIL rstmid_hilo: got %h exp 0", {bus.hi_o, bus.lo_o}); end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== 33) begin fails++; $display("FAIL rstmid_lat: got %0d exp 33", lat); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL rstmid_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    logic [63:0] e;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.src_a = 32'd7;
    bus.src_b = 32'd9;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== 33) begin fails++; $display("FAIL b2b_first_lat: got %0d exp 33", lat); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL b2b_first_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_we(lat, bcnt);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    tests++; if (lat !== MUL_LAT) begin fails++; $display("FAIL b2b_second_lat: got %0d exp %0d", lat, MUL_LAT); end
    tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL b2b_second_val: got %h exp %h", {bus.hi_o, bus.lo_o}, e); end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [63:0] e;
    op_e o;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = op_e'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 2 == 1) b = -b;
      issue(o, a, b);
      wait_we(lat, bcnt);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      tests++; if (lat !== lat_of(o, b)) begin fails++; $display("FAIL rand%0d_lat: got %0d exp %0d", i, lat, lat_of(o, b)); end
      tests++; if ({bus.hi_o, bus.lo_o} !== e) begin fails++; $display("FAIL rand%0d_val op %0d a %h b %h: got %h exp %h", i, o, a, b, {bus.hi_o, bus.lo_o}, e); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = OP_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    test_reset();
    test_mult();
    test_divide();
    test_div0();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
